// File: rtl/mipi_tx_pkg.sv
// ============================================================================
//  Module   : mipi_tx_pkg
//  Purpose  : Shared constants and RAW12 byte-order helper for the CSI-2 TX packer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mipi_tx_pkg;

  localparam int RAW12_BYTES_PER_BEAT = 6;
  localparam int LANES                = 4;
  localparam int BUF_BYTES            = 16;
  localparam int READY_MAX_FILL       = 9;

  // Returns the three wire bytes of a RAW12 pixel pair; [7:0] is sent first.
  function automatic logic [23:0] raw12_pair_bytes(input logic [11:0] pa,
                                                   input logic [11:0] pb);
    return {pb[3:0], pa[3:0], pb[11:4], pa[11:4]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_tx_raw12_packer_if.sv
// ============================================================================
//  Module   : mipi_tx_raw12_packer_if
//  Purpose  : Pixel-in and word-out handshake bundle of the RAW12 packer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mipi_tx_raw12_packer_if;

  logic        pixel_valid_i;
  logic [47:0] pixel_i;
  logic        pixel_last_i;
  logic        pixel_ready_o;
  logic        output_ready_i;
  logic        output_valid_o;
  logic [31:0] output_o;
  logic [3:0]  output_keep_o;
  logic        output_last_o;

  modport slave (
    input  pixel_valid_i, pixel_i, pixel_last_i, output_ready_i,
    output pixel_ready_o, output_valid_o, output_o, output_keep_o, output_last_o
  );

  modport master (
    output pixel_valid_i, pixel_i, pixel_last_i, output_ready_i,
    input  pixel_ready_o, output_valid_o, output_o, output_keep_o, output_last_o
  );

endinterface

`default_nettype wire

// File: rtl/mipi_tx_raw12_beat_pack.sv
// ============================================================================
//  Module   : mipi_tx_raw12_beat_pack
//  Purpose  : Reorders one 4-pixel beat into six RAW12 wire bytes ([7:0] first).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipi_tx_raw12_beat_pack
  import mipi_tx_pkg::*;
(
  input  wire logic [47:0] pixel_i,
  output logic      [47:0] bytes_o
);

  assign bytes_o = {raw12_pair_bytes(pixel_i[23:12], pixel_i[11:0]),
                    raw12_pair_bytes(pixel_i[47:36], pixel_i[35:24])};

endmodule

`default_nettype wire

// File: rtl/mipi_tx_raw12_packer.sv
// ============================================================================
//  Module   : mipi_tx_raw12_packer
//  Purpose  : Packs 4x12-bit pixel beats into 32-bit 4-lane CSI-2 RAW12 words.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipi_tx_raw12_packer
  import mipi_tx_pkg::*;
(
  input  wire logic              clk_i,
  input  wire logic              reset_i,
  mipi_tx_raw12_packer_if.slave  bus
);

  localparam int         c_buf_w       = BUF_BYTES * 8;
  localparam int         c_beat_w      = RAW12_BYTES_PER_BEAT * 8;
  localparam logic [3:0] c_ready_max   = 4'(READY_MAX_FILL);
  localparam logic [3:0] c_beat_bytes  = 4'(RAW12_BYTES_PER_BEAT);
  localparam logic [3:0] c_lanes       = 4'(LANES);

  logic [c_buf_w-1:0]  buf_q,   buf_d;
  logic [3:0]          fill_q,  fill_d;
  logic                flush_q, flush_d;

  logic [c_beat_w-1:0] w_beat_bytes;
  logic                w_ready;
  logic                w_out_valid;
  logic                w_pop;
  logic                w_push;
  logic [2:0]          w_popped;
  logic [3:0]          w_base;
  logic [31:0]         w_word;
  logic [3:0]          w_keep;
  logic                w_last;

  mipi_tx_raw12_beat_pack u_beat_pack (
    .pixel_i (bus.pixel_i),
    .bytes_o (w_beat_bytes)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_q   <= '0;
      fill_q  <= 4'd0;
      flush_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    w_ready     = !flush_q && (fill_q <= c_ready_max);
    w_out_valid = (fill_q >= c_lanes) || (flush_q && (fill_q != 4'd0));
    w_pop       = w_out_valid && bus.output_ready_i;
    w_push      = bus.pixel_valid_i && w_ready;
    w_popped    = 3'd0;
    if (w_pop) begin
      w_popped = (fill_q >= c_lanes) ? 3'd4 : fill_q[2:0];
    end
    w_base = fill_q - {1'b0, w_popped};

    // Bytes above fill are always zero, so the new beat can simply be OR-ed in.
    buf_d = buf_q >> {w_popped, 3'b000};
    if (w_push) begin
      buf_d = buf_d | ({{(c_buf_w - c_beat_w){1'b0}}, w_beat_bytes} << {w_base, 3'b000});
    end
    fill_d = w_base + (w_push ? c_beat_bytes : 4'd0);

    flush_d = flush_q;
    if (w_push && bus.pixel_last_i) begin
      flush_d = 1'b1;
    end else if (flush_q && w_pop && (fill_q <= c_lanes)) begin
      flush_d = 1'b0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_word[k*8 +: 8] = (fill_q > 4'(k)) ? buf_q[k*8 +: 8] : 8'h00;
  end

  always_comb begin
    w_keep = 4'hF;
    w_last = 1'b0;
    if (flush_q && (fill_q <= c_lanes)) begin
      w_last = 1'b1;
      if (fill_q < c_lanes) begin
        w_keep = (4'd1 << fill_q[1:0]) - 4'd1;
      end
    end
  end

  assign bus.pixel_ready_o  = w_ready;
  assign bus.output_valid_o = w_out_valid;
  assign bus.output_o       = w_word;
  assign bus.output_keep_o  = w_keep;
  assign bus.output_last_o  = w_last;

endmodule

`default_nettype wire

// File: tb/tb_mipi_tx_raw12_packer.sv
// ============================================================================
//  Module   : tb_mipi_tx_raw12_packer
//  Purpose  : Directed bench with a byte-queue reference model for the RAW12 packer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mipi_tx_raw12_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mipi_tx_raw12_packer_if bus ();

  mipi_tx_raw12_packer dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq[$];
  bit          m_flush = 1'b0;
  logic [31:0] exp_words[$];
  logic [31:0] dut_words[$];
  logic [3:0]  dut_keeps[$];
  logic        dut_lasts[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue filled in wire order, drained 4 bytes at a time.
  function automatic bit m_ready();
    return !m_flush && (mq.size() <= 9);
  endfunction

  function automatic bit m_valid();
    return (mq.size() >= 4) || (m_flush && (mq.size() != 0));
  endfunction

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) if (i < mq.size()) w[i*8 +: 8] = mq[i];
    return w;
  endfunction

  function automatic logic [3:0] m_keep();
    logic [3:0] k;
    for (int i = 0; i < 4; i++) k[i] = !m_flush || (i < mq.size());
    return k;
  endfunction

  function automatic bit m_last();
    return m_flush && (mq.size() <= 4);
  endfunction

  task automatic model_push(input logic [47:0] p);
    logic [11:0] pa, pb;
    for (int k = 0; k < 2; k++) begin
      pa = p[47 - 24*k -: 12];
      pb = p[35 - 24*k -: 12];
      mq.push_back(pa[11:4]);
      mq.push_back(pb[11:4]);
      mq.push_back({pb[3:0], pa[3:0]});
    end
  endtask

  initial begin : p_model
    bit          v, r, pop, push, lst;
    logic [47:0] px;
    int          n;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_flush = 1'b0;
      end else begin
        v    = m_valid();
        r    = m_ready();
        pop  = v && bus.output_ready_i;
        push = bus.pixel_valid_i && r;
        lst  = bus.pixel_last_i;
        px   = bus.pixel_i;
        if (pop) begin
          exp_words.push_back(m_word());
          n = (mq.size() < 4) ? mq.size() : 4;
          repeat (n) void'(mq.pop_front());
          if (m_flush && mq.size() == 0) m_flush = 1'b0;
        end
        if (push) begin
          model_push(px);
          if (lst) m_flush = 1'b1;
        end
      end
    end
  end

  initial begin : p_compare
    forever begin
      @(negedge clk);
      check("pixel_ready", bus.pixel_ready_o, m_ready());
      check("out_valid",   bus.output_valid_o, m_valid());
      check("out_data",    bus.output_o, m_word());
      check("out_keep",    bus.output_keep_o, m_keep());
      check("out_last",    bus.output_last_o, m_last());
      if (bus.output_valid_o && bus.output_ready_i) begin
        dut_words.push_back(bus.output_o);
        dut_keeps.push_back(bus.output_keep_o);
        dut_lasts.push_back(bus.output_last_o);
      end
    end
  end

  task automatic send(input logic [47:0] p, input bit last);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 200;
    bus.pixel_valid_i = 1'b1;
    bus.pixel_i       = p;
    bus.pixel_last_i  = last;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = bus.pixel_ready_o;
      @(posedge clk);
      #1;
      budget--;
    end
    bus.pixel_valid_i = 1'b0;
    bus.pixel_last_i  = 1'b0;
    check("beat_accept", acc, 1'b1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((mq.size() != 0 || m_flush) && b < 200) begin
      @(posedge clk);
      b++;
    end
    @(posedge clk);
    #1;
    check("drain_idle", bus.output_valid_o, 1'b0);
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] w,
                            input logic [3:0] k, input logic l);
    if (idx < dut_words.size()) begin
      check({name, "_data"}, dut_words[idx], w);
      check({name, "_keep"}, dut_keeps[idx], k);
      check({name, "_last"}, dut_lasts[idx], l);
    end else begin
      check({name, "_present"}, dut_words.size(), idx + 1);
    end
    if (idx < exp_words.size()) check({name, "_model"}, exp_words[idx], w);
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int base;
    int c0;
    bus.pixel_valid_i  = 1'b0;
    bus.pixel_i        = '0;
    bus.pixel_last_i   = 1'b0;
    bus.output_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.pixel_ready_o, 1'b1);
    check("rst_valid", bus.output_valid_o, 1'b0);
    check("rst_data",  bus.output_o, 32'h0);
    check("rst_keep",  bus.output_keep_o, 4'hF);
    check("rst_last",  bus.output_last_o, 1'b0);
    rst = 1'b0;

    // Single beat line: odd beat count ends on a 2-byte word.
    base = dut_words.size();
    send({12'hABC, 12'h123, 12'h456, 12'h789}, 1'b1);
    drain();
    check("t1_count", dut_words.size() - base, 2);
    check_word("t1_w0", base,     32'h453C12AB, 4'hF, 1'b0);
    check_word("t1_w1", base + 1, 32'h00009678, 4'h3, 1'b1);

    // Two-beat line: even beat count ends on a full word.
    base = dut_words.size();
    send({12'hABC, 12'h123, 12'h456, 12'h789}, 1'b0);
    send({12'h111, 12'h222, 12'h333, 12'h444}, 1'b1);
    drain();
    check("t2_count", dut_words.size() - base, 3);
    check_word("t2_w1", base + 1, 32'h22119678, 4'hF, 1'b0);
    check_word("t2_w2", base + 2, 32'h43443321, 4'hF, 1'b1);

    // Sixteen back-to-back beats at full output rate.
    base = dut_words.size();
    c0   = cyc;
    for (int i = 0; i < 16; i++) begin
      send({12'(i * 37 + 1), 12'(i * 91 + 2), 12'(i * 13 + 3), 12'(12'hF00 ^ i)}, i == 15);
    end
    drain();
    check("t3_count", dut_words.size() - base, 24);
    check("t3_fast", (cyc - c0) <= 30, 1'b1);

    // Output stall of six cycles in mid-stream.
    base = dut_words.size();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send({12'(i + 12'h5A0), 12'(i * 3), 12'(12'h0FF - i), 12'(i * 211)}, i == 7);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.output_ready_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.output_ready_i = 1'b1;
      end
    join
    drain();
    check("t4_count", dut_words.size() - base, 12);

    // Asynchronous reset with fill = 10 and flush pending.
    send({12'hABC, 12'h123, 12'h456, 12'h789}, 1'b0);
    send({12'hABC, 12'h123, 12'h456, 12'h789}, 1'b0);
    send({12'hABC, 12'h123, 12'h456, 12'h789}, 1'b1);
    bus.output_ready_i = 1'b0;
    #2;
    check("t5_pre_valid", bus.output_valid_o, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_ready", bus.pixel_ready_o, 1'b1);
    check("t5_valid", bus.output_valid_o, 1'b0);
    check("t5_data",  bus.output_o, 32'h0);
    check("t5_keep",  bus.output_keep_o, 4'hF);
    check("t5_last",  bus.output_last_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.output_ready_i = 1'b1;
    base = dut_words.size();
    send({12'hABC, 12'h123, 12'h456, 12'h789}, 1'b1);
    drain();
    check_word("t5_w0", base,     32'h453C12AB, 4'hF, 1'b0);
    check_word("t5_w1", base + 1, 32'h00009678, 4'h3, 1'b1);

    // Valid held through a flush: the next line waits for the last word.
    base = dut_words.size();
    send({12'h123, 12'h456, 12'h789, 12'hABC}, 1'b1);
    send({12'h123, 12'h456, 12'h789, 12'hABC}, 1'b1);
    drain();
    check("t6_count", dut_words.size() - base, 4);
    check_word("t6_w0", base,     32'h78634512, 4'hF, 1'b0);
    check_word("t6_w1", base + 1, 32'h0000C9AB, 4'h3, 1'b1);
    check_word("t6_w3", base + 3, 32'h0000C9AB, 4'h3, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
